// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_param
// Brief    : Full-duplex UART; TX and RX share one oversampling tick.
//            Optional parity bit when UART_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int MAIN_CLK   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
    localparam int c_div   = MAIN_CLK / (BAUD * OVERSAMPLE);
    localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_os_w  = $clog2(OVERSAMPLE);
    localparam int c_bit_w = $clog2(DATA_BITS);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_os_w-1:0]  c_os_last  = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_os_w-1:0]  c_os_half  = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);
    localparam logic               c_stop_last = 1'(STOP_BITS - 1);
    localparam logic               c_par_odd  = (PARITY_ODD != 0);

    localparam logic [2:0] c_tx_idle   = 3'd0;
    localparam logic [2:0] c_tx_wait   = 3'd1;
    localparam logic [2:0] c_tx_start  = 3'd2;
    localparam logic [2:0] c_tx_data   = 3'd3;
    localparam logic [2:0] c_tx_stop   = 3'd5;
    localparam logic [2:0] c_rx_idle   = 3'd0;
    localparam logic [2:0] c_rx_start  = 3'd1;
    localparam logic [2:0] c_rx_data   = 3'd2;
    localparam logic [2:0] c_rx_stop   = 3'd4;
    localparam logic [2:0] c_rx_hold   = 3'd5;
`ifdef UART_PARITY_EN
    localparam logic [2:0] c_tx_parity = 3'd4;
    localparam logic [2:0] c_rx_parity = 3'd3;
`endif

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 || c_div < 1)
    begin : g_bad_params
        $error("uart_core_param: illegal parameter set");
    end

    // Shared oversampling tick: one-cycle strobe every c_div clocks
    logic [c_div_w-1:0] r_div_cnt;
    logic               w_tick;
    assign w_tick = (r_div_cnt == c_div_last);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)      r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + c_div_w'(1);
    end

    // ------------------------------------------------------------------ TX
    logic [2:0]           r_tx_state, w_tx_next;
    logic [c_os_w-1:0]    r_tx_tick_cnt;
    logic [c_bit_w-1:0]   r_tx_bit_idx;
    logic                 r_tx_stop_idx;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 w_tx_bit_end, w_tx_last_stop;

    assign w_tx_bit_end   = w_tick && (r_tx_tick_cnt == c_os_last);
    assign w_tx_last_stop = (r_tx_state == c_tx_stop) && w_tx_bit_end &&
                            (r_tx_stop_idx == c_stop_last);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) r_tx_state <= c_tx_idle;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            c_tx_idle:  if (tx_valid) w_tx_next = c_tx_wait;
            c_tx_wait:  if (w_tick) w_tx_next = c_tx_start;
            c_tx_start: if (w_tx_bit_end) w_tx_next = c_tx_data;
            c_tx_data: begin
                if (w_tx_bit_end && (r_tx_bit_idx == c_bit_last)) begin
`ifdef UART_PARITY_EN
                    w_tx_next = c_tx_parity;
`else
                    w_tx_next = c_tx_stop;
`endif
                end
            end
`ifdef UART_PARITY_EN
            c_tx_parity: if (w_tx_bit_end) w_tx_next = c_tx_stop;
`endif
            // A byte waiting at the end of the last stop bit starts with no gap
            c_tx_stop:  if (w_tx_last_stop) w_tx_next = tx_valid ? c_tx_start : c_tx_idle;
            default:    w_tx_next = c_tx_idle;
        endcase
    end

    always_comb begin
        tx_ready = (r_tx_state == c_tx_idle) || w_tx_last_stop;
        case (r_tx_state)
            c_tx_start:  uart_tx = 1'b0;
            c_tx_data:   uart_tx = r_tx_data[r_tx_bit_idx];
`ifdef UART_PARITY_EN
            c_tx_parity: uart_tx = (^r_tx_data) ^ c_par_odd;
`endif
            default:     uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data     <= '0;
            r_tx_tick_cnt <= '0;
            r_tx_bit_idx  <= '0;
            r_tx_stop_idx <= 1'b0;
        end else begin
            if (tx_valid && tx_ready) r_tx_data <= tx_data;

            if (r_tx_state == c_tx_idle || r_tx_state == c_tx_wait) r_tx_tick_cnt <= '0;
            else if (w_tick) r_tx_tick_cnt <= (r_tx_tick_cnt == c_os_last) ? '0
                                              : r_tx_tick_cnt + c_os_w'(1);

            if (r_tx_state != c_tx_data) r_tx_bit_idx <= '0;
            else if (w_tx_bit_end)       r_tx_bit_idx <= r_tx_bit_idx + c_bit_w'(1);

            if (r_tx_state != c_tx_stop) r_tx_stop_idx <= 1'b0;
            else if (w_tx_bit_end)       r_tx_stop_idx <= ~r_tx_stop_idx;
        end
    end

    // ------------------------------------------------------------------ RX
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic [2:0]           r_rx_state, w_rx_next;
    logic [c_os_w-1:0]    r_rx_tick_cnt;
    logic [c_bit_w-1:0]   r_rx_bit_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 w_rx_half, w_rx_centre, w_rx_shift_en, w_rx_deliver;

    assign w_rx_half   = w_tick && (r_rx_tick_cnt == c_os_half);
    assign w_rx_centre = w_tick && (r_rx_tick_cnt == c_os_last);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) r_rx_state <= c_rx_idle;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            c_rx_idle:  if (r_rx_prev && !r_rx_sync) w_rx_next = c_rx_start;
            c_rx_start: if (w_rx_half) w_rx_next = r_rx_sync ? c_rx_idle : c_rx_data;
            c_rx_data: begin
                if (w_rx_centre && (r_rx_bit_idx == c_bit_last)) begin
`ifdef UART_PARITY_EN
                    w_rx_next = c_rx_parity;
`else
                    w_rx_next = c_rx_stop;
`endif
                end
            end
`ifdef UART_PARITY_EN
            c_rx_parity: if (w_rx_centre) w_rx_next = c_rx_stop;
`endif
            c_rx_stop:  if (w_rx_centre) w_rx_next = r_rx_sync ? c_rx_idle : c_rx_hold;
            c_rx_hold:  if (r_rx_sync) w_rx_next = c_rx_idle;
            default:    w_rx_next = c_rx_idle;
        endcase
    end

    always_comb begin
        w_rx_shift_en = (r_rx_state == c_rx_data) && w_rx_centre;
        w_rx_deliver  = (r_rx_state == c_rx_stop) && w_rx_centre;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta     <= 1'b1;
            r_rx_sync     <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_rx_tick_cnt <= '0;
            r_rx_bit_idx  <= '0;
            r_rx_shift    <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;

            // Restart at the start-bit centre so later samples land on bit centres
            if (r_rx_state == c_rx_idle || r_rx_state == c_rx_hold) r_rx_tick_cnt <= '0;
            else if (w_tick) begin
                if ((r_rx_state == c_rx_start && r_rx_tick_cnt == c_os_half) ||
                    r_rx_tick_cnt == c_os_last)
                    r_rx_tick_cnt <= '0;
                else
                    r_rx_tick_cnt <= r_rx_tick_cnt + c_os_w'(1);
            end

            if (r_rx_state != c_rx_data) r_rx_bit_idx <= '0;
            else if (w_rx_centre)        r_rx_bit_idx <= r_rx_bit_idx + c_bit_w'(1);

            if (w_rx_shift_en) r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};

            rx_valid <= w_rx_deliver;
            if (w_rx_deliver) begin
                rx_data      <= r_rx_shift;
                rx_frame_err <= ~r_rx_sync;
            end
        end
    end

`ifdef UART_PARITY_EN
    logic r_rx_par_bit;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_par_bit  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if ((r_rx_state == c_rx_parity) && w_rx_centre) r_rx_par_bit <= r_rx_sync;
            if (w_rx_deliver) rx_parity_err <= ((^r_rx_shift) ^ c_par_odd) != r_rx_par_bit;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_core_param
// Brief    : Directed self-checking bench for uart_core_param (DIV = 5, 80 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;
    localparam int c_main_clk = 50_000_000;
    localparam int c_baud     = 625_000;
    localparam int c_div      = 5;
    localparam int c_bit      = 80;
`ifdef UART_PARITY_EN
    localparam int c_frame_bits = 11;
`else
    localparam int c_frame_bits = 10;
`endif
    localparam int c_frame = c_frame_bits * c_bit;

    logic       clk_50M  = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err;
    logic       loop_en  = 1'b0;
    logic       rx_drv   = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rx_rec_t;
    rx_rec_t rxq[$];

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    always #10 clk_50M = ~clk_50M;

    uart_core_param #(
        .MAIN_CLK(c_main_clk), .BAUD(c_baud), .OVERSAMPLE(16),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk_50M(clk_50M), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .uart_tx(uart_tx),
        .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    always @(negedge clk_50M) if (rx_valid) rxq.push_back({rx_data, rx_frame_err, rx_parity_err});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (tx_ready) begin ok = 1'b1; break; end
            @(negedge clk_50M);
        end
    endtask

    task automatic wait_tx_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (uart_tx == 1'b0) begin ok = 1'b1; break; end
            @(negedge clk_50M);
        end
    endtask

    task automatic wait_rx(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rxq.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk_50M);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
        rx_drv = 1'b0;
        repeat (c_bit) @(negedge clk_50M);
        for (int k = 0; k < 8; k++) begin
            rx_drv = d[k];
            repeat (c_bit) @(negedge clk_50M);
        end
`ifdef UART_PARITY_EN
        rx_drv = par;
        repeat (c_bit) @(negedge clk_50M);
`endif
        rx_drv = stop;
        repeat (c_bit) @(negedge clk_50M);
        rx_drv = 1'b1;
        repeat (2 * c_bit) @(negedge clk_50M);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        bit ok;
        rx_rec_t r;
        wait_rx(1, 2 * c_frame, ok);
        check({tag, "_seen"}, ok, 1);
        r = (rxq.size() > 0) ? rxq.pop_front() : rx_rec_t'('1);
        check({tag, "_data"}, r.d, d);
        check({tag, "_ferr"}, r.fe, fe);
        check({tag, "_perr"}, r.pe, pe);
    endtask

    // Sends d and checks every bit at its centre, the ready window and the idle state after.
    task automatic tx_frame_check(input logic [7:0] d);
        logic [10:0] exp_bits;
        int          low_cnt;
        bit          ok;
        exp_bits    = '1;
        exp_bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_bits[k+1] = d[k];
`ifdef UART_PARITY_EN
        exp_bits[9] = ^d;
`endif
        @(negedge clk_50M);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_ready(4 * c_bit, ok);
        @(negedge clk_50M);
        tx_valid = 1'b0;
        tx_data  = ~d;
        check("tx_ready_busy", tx_ready, 0);
        wait_tx_low(2 * c_div, ok);
        check("tx_start_latency", ok, 1);
        low_cnt = 0;
        for (int i = 0; i < c_frame; i++) begin
            if (i == 3 * c_bit) tx_valid = 1'b1;
            if (i == 3 * c_bit + 1) tx_valid = 1'b0;
            if (i % c_bit == c_bit / 2)
                check($sformatf("tx_%0h_bit%0d", d, i / c_bit), uart_tx, exp_bits[i / c_bit]);
            if (!tx_ready) low_cnt++;
            @(negedge clk_50M);
        end
        check("tx_ready_low_cycles", low_cnt, c_frame - 1);
        check("tx_ready_idle", tx_ready, 1);
        check("tx_line_idle", uart_tx, 1);
    endtask

    initial begin
        repeat (200_000) @(posedge clk_50M);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [7:0] exp_b2b [3];
        exp_b2b[0] = 8'h00;
        exp_b2b[1] = 8'hFF;
        exp_b2b[2] = 8'h3C;

        // Reset values
        repeat (5) @(negedge clk_50M);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_ferr", rx_frame_err, 0);
        check("rst_rx_perr", rx_parity_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50M);

        // Single frame, 0xA5
        tx_frame_check(8'hA5);

        // Loopback, three back-to-back frames
        loop_en = 1'b1;
        rxq.delete();
        @(negedge clk_50M);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk_50M);
        tx_data = 8'hFF;
        wait_tx_low(2 * c_div, ok);
        check("b2b_first_start", ok, 1);
        fork
            begin
                bit ok1;
                wait_ready(c_frame + 10, ok1);
                check("b2b_accept_ff", ok1, 1);
                @(negedge clk_50M);
                tx_data = 8'h3C;
                wait_ready(c_frame + 10, ok1);
                check("b2b_accept_3c", ok1, 1);
                @(negedge clk_50M);
                tx_valid = 1'b0;
            end
            begin
                repeat (c_frame + 2) @(negedge clk_50M);
                check("b2b_no_gap1", uart_tx, 0);
                repeat (c_frame) @(negedge clk_50M);
                check("b2b_no_gap2", uart_tx, 0);
            end
        join
        wait_rx(3, 2 * c_frame, ok);
        check("b2b_rx_count", rxq.size(), 3);
        for (int k = 0; k < 3; k++) check_rx($sformatf("b2b_rx%0d", k), exp_b2b[k], 1'b0, 1'b0);
        loop_en = 1'b0;
        repeat (2 * c_bit) @(negedge clk_50M);

        // Short low pulse on the line is rejected, next frame is clean
        rxq.delete();
        rx_drv = 1'b0;
        repeat (25) @(negedge clk_50M);
        rx_drv = 1'b1;
        repeat (4 * c_bit) @(negedge clk_50M);
        check("glitch_no_rx", rxq.size(), 0);
        drive_frame(8'h55, 1'b0, 1'b1);
        check_rx("rx_55", 8'h55, 1'b0, 1'b0);

        // Framing error is delivered with the data
        drive_frame(8'h81, 1'b0, 1'b0);
        check_rx("rx_81_ferr", 8'h81, 1'b1, 1'b0);
        repeat (c_bit) @(negedge clk_50M);
        check("rx_hold_data", rx_data, 8'h81);
        check("rx_hold_ferr", rx_frame_err, 1);

        // Parity bit on TX and parity error on RX
        tx_frame_check(8'h07);
`ifdef UART_PARITY_EN
        drive_frame(8'h07, 1'b0, 1'b1);
        check_rx("rx_07_bad_par", 8'h07, 1'b0, 1'b1);
        drive_frame(8'h07, 1'b1, 1'b1);
        check_rx("rx_07_good_par", 8'h07, 1'b0, 1'b0);
`endif

        // Reset during TX data bit 4 and RX data bit 3
        rxq.delete();
        @(negedge clk_50M);
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(negedge clk_50M);
        tx_valid = 1'b0;
        wait_tx_low(2 * c_div, ok);
        check("mid_rst_tx_start", ok, 1);
        fork
            begin
                repeat (60) @(negedge clk_50M);
                drive_frame(8'hC3, ^8'hC3, 1'b1);
            end
            begin
                repeat (5 * c_bit + c_bit / 2) @(negedge clk_50M);
                check("mid_rst_tx_bit4_low", uart_tx, 0);
                rst_n = 1'b0;
                #1;
                check("mid_rst_uart_tx", uart_tx, 1);
                check("mid_rst_tx_ready", tx_ready, 1);
                check("mid_rst_rx_valid", rx_valid, 0);
                repeat (c_frame + 2 * c_bit) @(negedge clk_50M);
                rst_n = 1'b1;
            end
        join
        repeat (2 * c_bit) @(negedge clk_50M);
        check("mid_rst_no_rx", rxq.size(), 0);
        check("post_rst_uart_tx", uart_tx, 1);
        check("post_rst_tx_ready", tx_ready, 1);
        drive_frame(8'h96, ^8'h96, 1'b1);
        check_rx("post_rst_rx_96", 8'h96, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
